bk_operand_recover: RTL and testbench
=====================================

Name: bk_operand_recover

Overview:
- Inverse companion to the team's 12-bit Brent-Kung adder. Takes an adder result SUM (13 bits, carry-out in MSB) and one known operand A, and returns the other operand B = SUM − A.
- Two-stage pipelined borrow-lookahead subtractor with valid/ready handshakes on both sides.
- Used on the checker/readback path to reconstruct the second operand from captured adder outputs.

Parameters:
- WIDTH, 12, operand width; SUM is WIDTH+1 bits.
- SPLIT, 6, number of low bits whose difference and group borrow are resolved in stage 1; must satisfy 1 ≤ SPLIT < WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  INPUTS holds a transaction.
- in_ready  output  1  block accepts INPUTS this cycle.
- INPUTS  input  2*WIDTH+1  {A[WIDTH-1:0], SUM[WIDTH:0]}; SUM occupies the LSBs.
- out_valid  output  1  OUTS holds a result.
- out_ready  input  1  downstream accepts OUTS this cycle.
- OUTS  output  WIDTH+1  {range_err, B[WIDTH-1:0]}.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, OUTS=0, in_ready=1 in the first cycle after reset. Data registers need no reset.
- Reset mid-operation: all in-flight transactions are discarded, with no output pulse.
- Arithmetic:
  - diff = {1'b0,SUM} − {2'b0,A}, computed WIDTH+2 bits wide.
  - B = diff[WIDTH-1:0], i.e. modulo 2^WIDTH.
  - range_err = 1 if SUM < A (borrow out) or diff ≥ 2^WIDTH (diff[WIDTH]=1). Otherwise range_err = 0.
- Stage 1 (on accept):
  - Register the low SPLIT difference bits and the low-group borrow.
  - Register the raw upper SUM/A slices, or their bitwise generate/propagate.
- Stage 2:
  - Resolve the upper bits using the stage-1 borrow.
  - Form range_err and register OUTS.
- Latency: exactly 2 cycles from in_valid&&in_ready to out_valid, when there is no backpressure.
- Throughput: 1 transaction per cycle.
- Handshake:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid && s2 advances.
  - in_ready = !s1_valid || s2 advances. This is combinational from out_ready; no combinational path from in_valid to in_ready.
- Stall rules:
  - out_valid && !out_ready: OUTS and out_valid hold stable.
  - s1 holds if it is occupied.
  - in_ready drops once both stages are full.
- Simultaneous output accept and new input with a full pipe: both handshakes complete in the same cycle, with no bubble.
- Ordering: results emerge in input order. No drop, no duplication.
- Outputs when idle: OUTS holds its last value when out_valid=0. Consumers must not sample it.

Optional Feature:
- Macro: BK_RECOVER_ERRCNT_EN.
- When defined:
  - Adds output port err_count (16 bits).
  - Counts output handshakes with range_err=1.
  - Saturates at 0xFFFF.
  - Clears to 0 on rst.
  - Increments in the same cycle as the qualifying out_valid&&out_ready.
- When undefined: no port, no counter logic. Datapath and handshake behaviour are identical in both builds.

Test Plan:
- A=0x123, SUM=0x0579, out_ready=1 → 2 cycles later out_valid=1, OUTS=0x0456 (B=0x456, err=0).
- Max operands: A=0xFFF, SUM=0x1FFE → B=0xFFF, err=0. Then A=0x000, SUM=0x0000 → B=0x000, err=0.
- Out of range:
  - A=0x001, SUM=0x0000 → OUTS=0x1FFF (B=0xFFF, err=1).
  - A=0x000, SUM=0x1FFF → OUTS=0x1FFF (err=1).
  - With BK_RECOVER_ERRCNT_EN, err_count=2.
- Backpressure:
  - Stream 4 back-to-back transactions; hold out_ready=0 for 3 cycles.
  - Expect in_ready=0 after 2 accepted, OUTS stable while stalled.
  - Release → all 4 results in order, no gaps.
- Full-pipe concurrency: with both stages full, assert out_ready=1 and in_valid=1 together → both handshakes fire that cycle, and the next result appears the following cycle.
- Reset mid-operation: assert rst for 1 cycle with 2 transactions in flight → out_valid=0 next cycle, in_ready=1, no stale result emitted, err_count=0.

Source files
------------

// File: rtl/bk_operand_recover.sv
// Recovers operand B = SUM - A from a 12-bit Brent-Kung adder result, as a two-stage borrow-lookahead pipeline.
// Optional macro BK_RECOVER_ERRCNT_EN adds a saturating 16-bit count of out-of-range results (err_count).

// Brent-Kung borrow prefix network: bout[i] is the borrow into bit i, bout[N] the group borrow out.
module bk_borrow_prefix #(
  parameter int N = 6
) (
  input  logic [N-1:0] g_in,
  input  logic [N-1:0] p_in,
  input  logic         bin,
  output logic [N:0]   bout
);

  function automatic int top_span();
    int d;
    d = 0;
    for (int s = 1; 2 * s < N; s = s * 2) d = s;
    return d;
  endfunction

  localparam int TOP = top_span();

  always_comb begin : prefix
    logic [N-1:0] g;
    logic [N-1:0] p;
    g = g_in;
    p = p_in;
    for (int d = 1; d < N; d = d * 2) begin
      for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    // Down-sweep fills in the prefixes the up-sweep tree skipped.
    for (int d = TOP; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    bout[0] = bin;
    for (int i = 0; i < N; i++) bout[i+1] = g[i] | (p[i] & bin);
  end

endmodule

module bk_operand_recover #(
  parameter int WIDTH = 12,
  parameter int SPLIT = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH:0]   INPUTS,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     OUTS
`ifdef BK_RECOVER_ERRCNT_EN
  ,
  output logic [15:0]        err_count
`endif
);

  // Upper slice includes the SUM carry-out bit so diff[WIDTH] falls out of the same network.
  localparam int HW = WIDTH - SPLIT + 1;

  logic [WIDTH:0]   in_sum;
  logic [WIDTH-1:0] in_a;
  logic [SPLIT-1:0] lo_g, lo_p, lo_diff;
  logic [SPLIT:0]   lo_bout;
  logic [HW-1:0]    hi_x, hi_y, hi_g, hi_p;

  logic             s1_valid, s2_valid;
  logic [SPLIT-1:0] s1_lo_diff;
  logic             s1_lo_borrow;
  logic [HW-1:0]    s1_hi_g, s1_hi_p;

  logic [HW:0]      hi_bout;
  logic [HW-1:0]    hi_diff;
  logic             range_err;
  logic [WIDTH:0]   result;

  logic             s2_adv, s1_adv, accept;

  assign in_sum = INPUTS[WIDTH:0];
  assign in_a   = INPUTS[2*WIDTH:WIDTH+1];

  assign lo_g    = ~in_sum[SPLIT-1:0] & in_a[SPLIT-1:0];
  assign lo_p    = ~(in_sum[SPLIT-1:0] ^ in_a[SPLIT-1:0]);
  assign lo_diff = ~lo_p ^ lo_bout[SPLIT-1:0];

  bk_borrow_prefix #(.N(SPLIT)) u_lo_prefix (
    .g_in (lo_g),
    .p_in (lo_p),
    .bin  (1'b0),
    .bout (lo_bout)
  );

  assign hi_x = in_sum[WIDTH:SPLIT];
  assign hi_y = {1'b0, in_a[WIDTH-1:SPLIT]};
  assign hi_g = ~hi_x & hi_y;
  assign hi_p = ~(hi_x ^ hi_y);

  bk_borrow_prefix #(.N(HW)) u_hi_prefix (
    .g_in (s1_hi_g),
    .p_in (s1_hi_p),
    .bin  (s1_lo_borrow),
    .bout (hi_bout)
  );

  assign hi_diff   = ~s1_hi_p ^ hi_bout[HW-1:0];
  assign range_err = hi_bout[HW] | hi_diff[HW-1];
  assign result    = {range_err, hi_diff[HW-2:0], s1_lo_diff};

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_adv;
  assign in_ready  = !s1_valid || s2_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      OUTS     <= '0;
    end else begin
      if (accept)      s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (s2_adv)      s2_valid <= s1_valid;
      if (s1_adv)      OUTS     <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_lo_diff   <= lo_diff;
      s1_lo_borrow <= lo_bout[SPLIT];
      s1_hi_g      <= hi_g;
      s1_hi_p      <= hi_p;
    end
  end

`ifdef BK_RECOVER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_count <= '0;
    else if (out_valid && out_ready && OUTS[WIDTH] && (err_count != 16'hFFFF))
      err_count <= err_count + 16'd1;
  end
`else
  // This build carries no error counter.
`endif

endmodule

// File: tb/tb_bk_operand_recover.sv
// Self-checking bench for bk_operand_recover: directed vectors, handshake corner cases and
// randomized traffic scored against an integer-subtraction reference model.
module tb_bk_operand_recover;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] INPUTS;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] OUTS;
`ifdef BK_RECOVER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [12:0] drv_exp;
  logic [12:0] exp_q[$];
  int          model_errs = 0;

  always #5 clk = ~clk;

  bk_operand_recover dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .INPUTS    (INPUTS),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUTS      (OUTS)
`ifdef BK_RECOVER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  typedef struct {
    logic [11:0] a;
    logic [12:0] sum;
    logic [12:0] outs;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [12:0] refModel(input logic [11:0] a, input logic [12:0] sum);
    int  d;
    logic err;
    d   = int'(sum) - int'(a);
    err = (d < 0) || (d >= 4096);
    return {err, d[11:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a transaction on the input until it is accepted, returning just after the accepting edge.
  task automatic applyStimulus(input logic [11:0] a, input logic [12:0] sum, input logic [12:0] exp);
    bit accepted;
    accepted = 0;
    in_valid = 1'b1;
    INPUTS   = {a, sum};
    drv_exp  = exp;
    for (int c = 0; c < 100 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      tick();
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) tick();
    checkOutput("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic checkErrCount(input string name);
`ifdef BK_RECOVER_ERRCNT_EN
    checkOutput(name, {16'd0, err_count}, model_errs);
`else
    if (name.len() == 0) $display("[TB] unnamed counter check");
`endif
  endtask

  // Scoreboard: handshakes are decided at the next rising edge, so sample them mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_errs = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out", {19'd0, OUTS}, 32'hDEAD);
        end else begin
          logic [12:0] e;
          e = exp_q.pop_front();
          checkOutput("outs", {19'd0, OUTS}, {19'd0, e});
          if (e[12] && model_errs < 65535) model_errs++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(drv_exp);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] a;
    logic [12:0] s;
    logic [12:0] e0, e1, e2, e3;
    int sent;
    bit pending;

    vecs[0] = '{12'hFFF, 13'h1FFE, 13'h0FFF};
    vecs[1] = '{12'h000, 13'h0000, 13'h0000};
    vecs[2] = '{12'h001, 13'h0000, 13'h1FFF};
    vecs[3] = '{12'h000, 13'h1FFF, 13'h1FFF};
    vecs[4] = '{12'h03F, 13'h0040, 13'h0001};
    vecs[5] = '{12'h040, 13'h003F, 13'h1FFF};
    vecs[6] = '{12'h800, 13'h1000, 13'h0800};
    vecs[7] = '{12'hFFF, 13'h0FFF, 13'h0000};
    vecs[8] = '{12'h001, 13'h1000, 13'h0FFF};
    vecs[9] = '{12'h000, 13'h0FFF, 13'h0FFF};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; INPUTS = '0; drv_exp = '0;
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_outs", {19'd0, OUTS}, 32'd0);
    checkErrCount("rst_err_count");

    // Two-cycle latency.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    INPUTS    = {12'h123, 13'h0579};
    drv_exp   = 13'h0456;
    tick();
    in_valid = 1'b0;
    checkOutput("lat_cycle1", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("lat_cycle2", {31'd0, out_valid}, 32'd1);
    checkOutput("lat_outs", {19'd0, OUTS}, 32'h0456);
    tick();

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i].a, vecs[i].sum, vecs[i].outs);
    drain();
    checkErrCount("table_err_count");

    // Backpressure: fill both stages, stall three cycles, then release.
    e0 = refModel(12'h111, 13'h0222);
    e1 = refModel(12'h0AB, 13'h1000);
    e2 = refModel(12'h555, 13'h0100);
    e3 = refModel(12'hF0F, 13'h1F0F);
    out_ready = 1'b0;
    applyStimulus(12'h111, 13'h0222, e0);
    applyStimulus(12'h0AB, 13'h1000, e1);
    in_valid = 1'b1; INPUTS = {12'h555, 13'h0100}; drv_exp = e2;
    #1;
    checkOutput("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_hold_outs", {19'd0, OUTS}, {19'd0, e0});
      checkOutput("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("bp_no_gap", {31'd0, out_valid}, 32'd1);
      tick();
      if (k == 0) begin
        INPUTS = {12'hF0F, 13'h1F0F}; drv_exp = e3;
      end
      if (k == 1) in_valid = 1'b0;
    end
    drain();

    // Full pipe: output and input handshakes in the same cycle.
    e0 = refModel(12'h7FF, 13'h0800);
    e1 = refModel(12'h800, 13'h07FF);
    e2 = refModel(12'h3C3, 13'h1C3C);
    out_ready = 1'b0;
    applyStimulus(12'h7FF, 13'h0800, e0);
    applyStimulus(12'h800, 13'h07FF, e1);
    out_ready = 1'b1;
    in_valid = 1'b1; INPUTS = {12'h3C3, 13'h1C3C}; drv_exp = e2;
    #1;
    checkOutput("full_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("full_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("full_next_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("full_next_outs", {19'd0, OUTS}, {19'd0, e1});
    drain();

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    applyStimulus(12'h001, 13'h0000, refModel(12'h001, 13'h0000));
    applyStimulus(12'h000, 13'h1FFF, refModel(12'h000, 13'h1FFF));
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_outs", {19'd0, OUTS}, 32'd0);
    checkErrCount("midrst_err_count");
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Randomized traffic with random backpressure.
    sent = 0;
    pending = 0;
    for (int c = 0; c < 3000 && sent < 300; c++) begin
      if (!pending) in_valid = 1'b0;
      if (!pending && $urandom_range(0, 3) != 0) begin
        a = 12'($urandom_range(0, 4095));
        case ($urandom_range(0, 3))
          0: s = 13'(int'(a) + $urandom_range(0, 4095));
          1: s = 13'($urandom_range(0, 4095));
          2: s = {1'b1, 12'($urandom_range(0, 4095))};
          default: s = 13'($urandom_range(0, 8191));
        endcase
        INPUTS   = {a, s};
        drv_exp  = refModel(a, s);
        in_valid = 1'b1;
        pending  = 1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        pending = 0;
        sent++;
      end
      tick();
    end
    checkOutput("random_sent", sent, 32'd300);
    drain();
    checkErrCount("random_err_count");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
